// File: rtl/ex_mem_access.sv
// ex_mem_access: memory-stage access unit. Checks alignment/overflow, runs a
// req/ack data-bus transaction and returns extended load data to writeback.
`default_nettype none

module ex_mem_access #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic        ex_dmov,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        ex_ready,
    input  logic        flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_badvaddr,
    output logic        busy
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    // Counter value reached on the last permitted REQ cycle without ack.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  tmo_cnt;
    logic        kill;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [4:0]  rd_q;

    logic        is_load;
    logic        is_store;
    logic        is_word;
    logic        is_half;
    logic        misaligned;
    logic        accept;
    logic        addr_exc;
    logic        start;
    logic        in_req;
    logic        timeout_hit;
    logic        suppress;
    logic        q_is_load;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [31:0] ld_data;

    // Request decode
    always_comb begin
        is_load    = (ex_op >= OP_LW) && (ex_op <= OP_LBU);
        is_store   = (ex_op >= OP_SW) && (ex_op <= OP_SB);
        is_word    = (ex_op == OP_LW) || (ex_op == OP_SW);
        is_half    = (ex_op == OP_LH) || (ex_op == OP_LHU) || (ex_op == OP_SH);
        misaligned = (is_word && (ex_addr[1:0] != 2'b00)) || (is_half && ex_addr[0]);
        accept     = ex_valid && (state == S_IDLE) && (is_load || is_store);
        addr_exc   = accept && (ex_dmov || misaligned);
        start      = accept && !addr_exc;
    end

    always_comb begin
        in_req      = (state == S_REQ);
        timeout_hit = in_req && !bus_ack && (tmo_cnt == TMO_LAST);
        // A flush on the completing edge kills the result just like an earlier one.
        suppress    = kill || flush;
        q_is_load   = (op_q >= OP_LW) && (op_q <= OP_LBU);
    end

    // Store lane steering: data is replicated so the byte enables pick the lane.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_wdata;
        case (ex_op)
            OP_SH: begin
                st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_wdata[15:0]}};
            end
            OP_SB: begin
                st_be    = 4'b0001 << ex_addr[1:0];
                st_wdata = {4{ex_wdata[7:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = ex_wdata;
            end
        endcase
    end

    // Little-endian load extraction from the latched address
    always_comb begin
        ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ld_byte = bus_rdata[7:0];
        case (addr_q[1:0])
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        case (op_q)
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'h0000, ld_half};
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'h000000, ld_byte};
            default: ld_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_REQ;
            S_REQ:  if (bus_ack || timeout_hit) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign ex_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt      <= 8'd0;
            kill         <= 1'b0;
            op_q         <= 4'd0;
            addr_q       <= 32'd0;
            rd_q         <= 5'd0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'd0;
            bus_be       <= 4'd0;
            bus_wdata    <= 32'd0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'd0;
            exc_valid    <= 1'b0;
            exc_code     <= 5'd0;
            exc_badvaddr <= 32'd0;
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;

            if (start) begin
                op_q      <= ex_op;
                addr_q    <= ex_addr;
                rd_q      <= ex_rd;
                bus_req   <= 1'b1;
                bus_we    <= is_store;
                bus_addr  <= {ex_addr[31:2], 2'b00};
                bus_be    <= st_be;
                bus_wdata <= st_wdata;
                tmo_cnt   <= 8'd0;
                kill      <= 1'b0;
            end

            if (addr_exc && !flush) begin
                exc_valid    <= 1'b1;
                exc_code     <= is_store ? EXC_ADES : EXC_ADEL;
                exc_badvaddr <= ex_addr;
            end

            if (in_req) begin
                if (bus_ack) begin
                    bus_req <= 1'b0;
                    kill    <= 1'b0;
                    tmo_cnt <= 8'd0;
                    if (q_is_load && !suppress) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= ld_data;
                    end
                end else if (timeout_hit) begin
                    bus_req <= 1'b0;
                    kill    <= 1'b0;
                    tmo_cnt <= 8'd0;
                    if (!suppress) begin
                        exc_valid    <= 1'b1;
                        exc_code     <= EXC_DBE;
                        exc_badvaddr <= addr_q;
                    end
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (flush) begin
                        kill <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_access.sv
// tb_ex_mem_access: directed self-checking bench for the memory-stage access unit.
`default_nettype none

module tb_ex_mem_access;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [31:0] ex_addr;
    logic        ex_dmov;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        ex_ready;
    logic        flush;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    int          mon_req;
    int          mon_unstable;
    int          mon_wb_cnt;
    int          mon_wb_at;
    logic [31:0] mon_wb_data;
    logic [4:0]  mon_wb_rd;
    int          mon_exc_cnt;
    int          mon_exc_at;
    logic [4:0]  mon_exc_code;
    logic [31:0] mon_exc_bad;
    logic        mon_we;
    logic [31:0] mon_addr;
    logic [3:0]  mon_be;
    logic [31:0] mon_wdata;

    ex_mem_access #(.TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_op        (ex_op),
        .ex_addr      (ex_addr),
        .ex_dmov      (ex_dmov),
        .ex_wdata     (ex_wdata),
        .ex_rd        (ex_rd),
        .ex_ready     (ex_ready),
        .flush        (flush),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .exc_badvaddr (exc_badvaddr),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one access and records bus/writeback/exception activity for 40 cycles.
    // ack_at / flush_at are 1-based REQ cycle numbers (0 = never).
    task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd,
                              input logic dmov, input int ack_at, input logic [31:0] rdata,
                              input int flush_at, input logic flush_acc);
        @(negedge clk);
        ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_wdata = wdata;
        ex_rd = rd; ex_dmov = dmov; flush = flush_acc;
        @(negedge clk);
        ex_valid = 1'b0; ex_op = 4'd0; ex_dmov = 1'b0; flush = 1'b0;
        mon_req = 0; mon_unstable = 0; mon_wb_cnt = 0; mon_wb_at = -1;
        mon_exc_cnt = 0; mon_exc_at = -1;
        for (int c = 0; c < 40; c++) begin
            if (bus_req) begin
                mon_req++;
                if (mon_req == 1) begin
                    mon_we = bus_we; mon_addr = bus_addr; mon_be = bus_be; mon_wdata = bus_wdata;
                end else if (bus_we !== mon_we || bus_addr !== mon_addr ||
                             bus_be !== mon_be || bus_wdata !== mon_wdata) begin
                    mon_unstable++;
                end
                if (mon_req == ack_at) begin
                    bus_ack = 1'b1; bus_rdata = rdata;
                end
                if (mon_req == flush_at) flush = 1'b1;
            end
            if (wb_valid) begin
                mon_wb_cnt++;
                if (mon_wb_at < 0) mon_wb_at = c;
                mon_wb_data = wb_data; mon_wb_rd = wb_rd;
            end
            if (exc_valid) begin
                mon_exc_cnt++;
                if (mon_exc_at < 0) mon_exc_at = c;
                mon_exc_code = exc_code; mon_exc_bad = exc_badvaddr;
            end
            @(negedge clk);
            bus_ack = 1'b0; flush = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        n_cmp++; if ({wb_valid, exc_valid} !== 2'b00) begin n_err++; $display("FAIL reset_valids: got %b want 00", {wb_valid, exc_valid}); end
        n_cmp++; if (wb_data !== 32'h0 || exc_code !== 5'h0 || bus_be !== 4'h0) begin
            n_err++; $display("FAIL reset_regs: got wb_data=%h exc_code=%h be=%h want 0", wb_data, exc_code, bus_be);
        end
        reset = 1'b1;
    endtask

    task automatic test_lw();
        run_access(4'd1, 32'h0000_0100, 32'h0, 5'd5, 1'b0, 4, 32'hDEAD_BEEF, 0, 1'b0);
        n_cmp++; if (mon_addr !== 32'h100 || mon_be !== 4'hF || mon_we !== 1'b0) begin
            n_err++; $display("FAIL lw_bus: got addr=%h be=%h we=%b want 100 f 0", mon_addr, mon_be, mon_we);
        end
        n_cmp++; if (mon_req !== 4) begin n_err++; $display("FAIL lw_busy_cycles: got %0d want 4", mon_req); end
        n_cmp++; if (mon_wb_at !== 4 || mon_wb_cnt !== 1) begin
            n_err++; $display("FAIL lw_wb_timing: got at=%0d cnt=%0d want 4 1", mon_wb_at, mon_wb_cnt);
        end
        n_cmp++; if (mon_wb_data !== 32'hDEAD_BEEF || mon_wb_rd !== 5'd5) begin
            n_err++; $display("FAIL lw_wb_data: got %h rd=%0d want deadbeef rd=5", mon_wb_data, mon_wb_rd);
        end
    endtask

    task automatic test_load_extend();
        logic [31:0] exp_tbl [5];
        logic [3:0]  op_tbl  [5];
        logic [31:0] adr_tbl [5];
        op_tbl  = '{4'd4, 4'd5, 4'd2, 4'd3, 4'd4};
        adr_tbl = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200};
        exp_tbl = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            run_access(op_tbl[i], adr_tbl[i], 32'h0, 5'd9, 1'b0, 2, 32'h80FF_FF7F, 0, 1'b0);
            n_cmp++; if (mon_wb_cnt !== 1 || mon_wb_data !== exp_tbl[i]) begin
                n_err++; $display("FAIL load_ext[%0d]: got cnt=%0d data=%h want 1 %h", i, mon_wb_cnt, mon_wb_data, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_store();
        run_access(4'd7, 32'h12, 32'h1234_ABCD, 5'd0, 1'b0, 3, 32'h0, 0, 1'b0);
        n_cmp++; if (mon_we !== 1'b1 || mon_be !== 4'b1100 || mon_addr !== 32'h10 || mon_wdata !== 32'hABCD_ABCD) begin
            n_err++; $display("FAIL sh_bus: got we=%b be=%b addr=%h wdata=%h want 1 1100 10 abcdabcd", mon_we, mon_be, mon_addr, mon_wdata);
        end
        n_cmp++; if (mon_wb_cnt !== 0 || mon_exc_cnt !== 0 || mon_unstable !== 0) begin
            n_err++; $display("FAIL sh_quiet: got wb=%0d exc=%0d unstable=%0d want 0 0 0", mon_wb_cnt, mon_exc_cnt, mon_unstable);
        end
        run_access(4'd8, 32'h13, 32'h0000_00EF, 5'd0, 1'b0, 1, 32'h0, 0, 1'b0);
        n_cmp++; if (mon_be !== 4'b1000 || mon_wdata !== 32'hEFEF_EFEF || mon_addr !== 32'h10) begin
            n_err++; $display("FAIL sb_bus: got be=%b wdata=%h addr=%h want 1000 efefefef 10", mon_be, mon_wdata, mon_addr);
        end
        run_access(4'd6, 32'h20, 32'hCAFE_F00D, 5'd0, 1'b0, 1, 32'h0, 0, 1'b0);
        n_cmp++; if (mon_be !== 4'b1111 || mon_wdata !== 32'hCAFE_F00D || mon_we !== 1'b1) begin
            n_err++; $display("FAIL sw_bus: got be=%b wdata=%h we=%b want 1111 cafef00d 1", mon_be, mon_wdata, mon_we);
        end
    endtask

    task automatic test_addr_exc();
        run_access(4'd1, 32'h102, 32'h0, 5'd3, 1'b0, 1, 32'h0, 0, 1'b0);
        n_cmp++; if (mon_exc_cnt !== 1 || mon_exc_at !== 0 || mon_exc_code !== 5'd4 || mon_exc_bad !== 32'h102) begin
            n_err++; $display("FAIL lw_misalign: got cnt=%0d at=%0d code=%0d bad=%h want 1 0 4 102", mon_exc_cnt, mon_exc_at, mon_exc_code, mon_exc_bad);
        end
        n_cmp++; if (mon_req !== 0) begin n_err++; $display("FAIL lw_misalign_bus: got req cycles %0d want 0", mon_req); end
        run_access(4'd8, 32'h40, 32'h0, 5'd0, 1'b1, 1, 32'h0, 0, 1'b0);
        n_cmp++; if (mon_exc_cnt !== 1 || mon_exc_code !== 5'd5 || mon_exc_bad !== 32'h40 || mon_req !== 0) begin
            n_err++; $display("FAIL sb_dmov: got cnt=%0d code=%0d bad=%h req=%0d want 1 5 40 0", mon_exc_cnt, mon_exc_code, mon_exc_bad, mon_req);
        end
        run_access(4'd7, 32'h11, 32'h0, 5'd0, 1'b0, 1, 32'h0, 0, 1'b0);
        n_cmp++; if (mon_exc_cnt !== 1 || mon_exc_code !== 5'd5 || mon_exc_bad !== 32'h11) begin
            n_err++; $display("FAIL sh_misalign: got cnt=%0d code=%0d bad=%h want 1 5 11", mon_exc_cnt, mon_exc_code, mon_exc_bad);
        end
        run_access(4'd12, 32'h1, 32'h0, 5'd0, 1'b1, 1, 32'h0, 0, 1'b0);
        n_cmp++; if (mon_exc_cnt !== 0 || mon_req !== 0) begin
            n_err++; $display("FAIL op_none: got exc=%0d req=%0d want 0 0", mon_exc_cnt, mon_req);
        end
    endtask

    task automatic test_timeout();
        run_access(4'd1, 32'h700, 32'h0, 5'd4, 1'b0, 0, 32'h0, 0, 1'b0);
        n_cmp++; if (mon_req !== 15) begin n_err++; $display("FAIL tmo_req_cycles: got %0d want 15", mon_req); end
        n_cmp++; if (mon_exc_cnt !== 1 || mon_exc_at !== 15 || mon_exc_code !== 5'd7 || mon_exc_bad !== 32'h700) begin
            n_err++; $display("FAIL tmo_exc: got cnt=%0d at=%0d code=%0d bad=%h want 1 15 7 700", mon_exc_cnt, mon_exc_at, mon_exc_code, mon_exc_bad);
        end
        run_access(4'd1, 32'h704, 32'h0, 5'd4, 1'b0, 15, 32'h1357_2468, 0, 1'b0);
        n_cmp++; if (mon_exc_cnt !== 0 || mon_wb_cnt !== 1 || mon_wb_data !== 32'h1357_2468) begin
            n_err++; $display("FAIL tmo_ack_wins: got exc=%0d wb=%0d data=%h want 0 1 13572468", mon_exc_cnt, mon_wb_cnt, mon_wb_data);
        end
    endtask

    task automatic test_flush();
        run_access(4'd1, 32'h500, 32'h0, 5'd6, 1'b0, 4, 32'h5555_AAAA, 2, 1'b0);
        n_cmp++; if (mon_wb_cnt !== 0 || mon_req !== 4) begin
            n_err++; $display("FAIL flush_req: got wb=%0d req=%0d want 0 4", mon_wb_cnt, mon_req);
        end
        run_access(4'd1, 32'h504, 32'h0, 5'd6, 1'b0, 2, 32'h0BAD_F00D, 0, 1'b0);
        n_cmp++; if (mon_wb_cnt !== 1 || mon_wb_data !== 32'h0BAD_F00D) begin
            n_err++; $display("FAIL flush_after: got wb=%0d data=%h want 1 0badf00d", mon_wb_cnt, mon_wb_data);
        end
        run_access(4'd1, 32'h508, 32'h0, 5'd6, 1'b0, 3, 32'h1111_2222, 3, 1'b0);
        n_cmp++; if (mon_wb_cnt !== 0) begin n_err++; $display("FAIL flush_on_ack: got wb=%0d want 0", mon_wb_cnt); end
        run_access(4'd2, 32'h501, 32'h0, 5'd6, 1'b0, 1, 32'h0, 0, 1'b1);
        n_cmp++; if (mon_exc_cnt !== 0 || mon_req !== 0) begin
            n_err++; $display("FAIL flush_exc: got exc=%0d req=%0d want 0 0", mon_exc_cnt, mon_req);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ex_valid = 1'b1; ex_op = 4'd1; ex_addr = 32'h300; ex_rd = 5'd7;
        @(negedge clk);
        ex_valid = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        @(negedge clk);
        bus_ack = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1 || ex_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_ready: got wb_valid=%b ex_ready=%b want 1 1", wb_valid, ex_ready);
        end
        ex_valid = 1'b1; ex_op = 4'd1; ex_addr = 32'h304; ex_rd = 5'd8;
        @(negedge clk);
        ex_valid = 1'b0; ex_op = 4'd0;
        n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h304 || wb_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_accept: got req=%b addr=%h wb=%b want 1 304 0", bus_req, bus_addr, wb_valid);
        end
        bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
        @(negedge clk);
        bus_ack = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h2222_2222 || wb_rd !== 5'd8) begin
            n_err++; $display("FAIL b2b_second: got wb=%b data=%h rd=%0d want 1 22222222 8", wb_valid, wb_data, wb_rd);
        end
    endtask

    task automatic test_reset_mid_req();
        int outs;
        @(negedge clk);
        ex_valid = 1'b1; ex_op = 4'd1; ex_addr = 32'h600; ex_rd = 5'd2;
        @(negedge clk);
        ex_valid = 1'b0; ex_op = 4'd0;
        n_cmp++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre: got req=%b want 1", bus_req); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus_req !== 1'b0 || ex_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_async: got req=%b ready=%b want 0 1", bus_req, ex_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        outs = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (wb_valid || exc_valid || bus_req) outs++;
        end
        n_cmp++; if (outs !== 0) begin n_err++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", outs); end
    endtask

    initial begin
        reset = 1'b0; ex_valid = 1'b0; ex_op = 4'd0; ex_addr = 32'h0; ex_dmov = 1'b0;
        ex_wdata = 32'h0; ex_rd = 5'd0; flush = 1'b0; bus_rdata = 32'h0; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_addr_exc();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_reset_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
